huffman_block_sequencer: RTL and testbench

- Sits between the zigzag reorder stage and the Huffman DC/AC encoders.
- Accepts one 64-coefficient zigzag block and computes the DC difference against a running predictor.
- Scans AC coefficients 1..63, run-length counting zeros, and emits one symbol per valid/ready handshake: DC diff, (run,value) pairs, ZRL and EOB.
- Replaces the fixed DC-then-AC split with a real per-symbol schedule.

---
 rtl/huffman_block_sequencer_if.sv | 24 ++
 rtl/huffman_block_sequencer.sv | 80 ++++++++
 tb/tb_huffman_block_sequencer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/huffman_block_sequencer_if.sv
// huffman_block_sequencer_if: block-in and symbol-out handshake bundles of the sequencer.
interface hbs_blk_if #(parameter int COEF_W = 8);
  logic                  blk_valid;
  logic                  blk_ready;
  logic [64*COEF_W-1:0]  zigzag_pix_in;
  logic                  dc_pred_clr;
  modport master (output blk_valid, output zigzag_pix_in, output dc_pred_clr, input blk_ready);
  modport slave  (input blk_valid, input zigzag_pix_in, input dc_pred_clr, output blk_ready);
endinterface

interface hbs_sym_if #(parameter int COEF_W = 8);
  logic              sym_valid;
  logic              sym_ready;
  logic              sym_is_dc;
  logic [3:0]        sym_run;
  logic [COEF_W:0]   sym_value;
  logic              sym_zrl;
  logic              sym_eob;
  logic              blk_done;
  modport master (output sym_valid, output sym_is_dc, output sym_run, output sym_value,
                  output sym_zrl, output sym_eob, output blk_done, input sym_ready);
  modport slave  (input sym_valid, input sym_is_dc, input sym_run, input sym_value,
                  input sym_zrl, input sym_eob, input blk_done, output sym_ready);
endinterface

// File: rtl/huffman_block_sequencer.sv
// huffman_block_sequencer: turns a zigzag block into DC-diff, run/value, ZRL and EOB symbols.
module huffman_block_sequencer #(
  parameter int COEF_W = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  hbs_blk_if.slave   blk,
  hbs_sym_if.master  sym
);
  typedef enum logic [2:0] {IDLE, DC, SCAN, ZRL, EOB, DONE} state_t;
  state_t                   state_q;
  logic signed [COEF_W-1:0] coef_q [64];
  logic signed [COEF_W-1:0] pred_q;
  logic [5:0]               idx_q;
  logic [5:0]               run_q;
  logic [COEF_W-1:0]        cur;
  logic                     cur_nz;
  logic                     ac_v;
  logic [COEF_W:0]          dc_diff;
  logic                     capture;
  assign capture = blk.blk_valid && state_q == IDLE;
  assign cur     = coef_q[idx_q];
  assign cur_nz  = cur != '0;
  assign ac_v    = state_q == SCAN && cur_nz && run_q[5:4] == 2'b00;
  assign dc_diff = {coef_q[0][COEF_W-1], coef_q[0]} - {pred_q[COEF_W-1], pred_q};
  assign blk.blk_ready = state_q == IDLE;
  assign sym.sym_valid = state_q == DC || state_q == ZRL || state_q == EOB || ac_v;
  assign sym.sym_is_dc = state_q == DC;
  assign sym.sym_zrl   = state_q == ZRL;
  assign sym.sym_eob   = state_q == EOB;
  assign sym.sym_run   = state_q == ZRL ? 4'd15 : ac_v ? run_q[3:0] : 4'd0;
  assign sym.sym_value = state_q == DC ? dc_diff : ac_v ? {cur[COEF_W-1], cur} : '0;
  assign sym.blk_done  = state_q == DONE;
  always_ff @(posedge clock)
    if (capture)
      for (int k = 0; k < 64; k++)
        coef_q[k] <= blk.zigzag_pix_in[64*COEF_W-1-k*COEF_W -: COEF_W];
  // ZRL is only entered once a nonzero is found, so trailing zeros fold into EOB
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pred_q  <= '0;
      idx_q   <= '0;
      run_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (blk.dc_pred_clr) pred_q <= '0;
          if (capture) state_q <= DC;
        end
        DC: if (sym.sym_ready) begin
          pred_q  <= coef_q[0];
          idx_q   <= 6'd1;
          run_q   <= '0;
          state_q <= SCAN;
        end
        SCAN: begin
          if (!cur_nz) begin
            if (idx_q == 6'd63) state_q <= EOB;
            else begin
              run_q <= run_q + 6'd1;
              idx_q <= idx_q + 6'd1;
            end
          end else if (run_q[5:4] != 2'b00) state_q <= ZRL;
          else if (sym.sym_ready) begin
            run_q <= '0;
            if (idx_q == 6'd63) state_q <= DONE;
            else idx_q <= idx_q + 6'd1;
          end
        end
        ZRL: if (sym.sym_ready) begin
          run_q   <= run_q - 6'd16;
          state_q <= SCAN;
        end
        EOB: if (sym.sym_ready) state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_huffman_block_sequencer.sv
// tb_huffman_block_sequencer: directed block scenarios with hand-computed symbol streams.
module tb_huffman_block_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  hbs_blk_if #(.COEF_W(8)) blk();
  hbs_sym_if #(.COEF_W(8)) sym();
  huffman_block_sequencer #(.COEF_W(8)) dut (.clock(clk), .reset_n(rst_n), .blk(blk), .sym(sym));
  int nvec = 0;
  int nerr = 0;
  logic [15:0] got[$];
  logic [15:0] exp_q[$];

  function automatic logic [15:0] s(bit dc, bit z, bit e, int run, int val);
    return {dc, z, e, 4'(run), 9'(val)};
  endfunction

  function automatic logic [511:0] blkv(int dc, int i1, int v1, int i2, int v2);
    logic [511:0] p = '0;
    p[511 -: 8] = 8'(dc);
    if (i1 > 0) p[511-i1*8 -: 8] = 8'(v1);
    if (i2 > 0) p[511-i2*8 -: 8] = 8'(v2);
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [511:0] p, input bit clr);
    int n = 0;
    while (!blk.blk_ready && n < 200) begin
      tick();
      n++;
    end
    nvec++;
    if (blk.blk_ready !== 1'b1) begin
      nerr++;
      $display("FAIL send_ready: blk_ready=%b required 1", blk.blk_ready);
    end
    blk.zigzag_pix_in = p;
    blk.blk_valid = 1'b1;
    blk.dc_pred_clr = clr;
    tick();
    blk.blk_valid = 1'b0;
    blk.dc_pred_clr = 1'b0;
  endtask

  task automatic collect(input bit chk_dc, input string name);
    int n = 0;
    got.delete();
    if (chk_dc) begin
      nvec++;
      if (sym.sym_valid !== 1'b1 || sym.sym_is_dc !== 1'b1) begin
        nerr++;
        $display("FAIL %s dc_latency: valid=%b is_dc=%b required 1 1", name, sym.sym_valid, sym.sym_is_dc);
      end
    end
    while (n < 300) begin
      if (sym.sym_valid && sym.sym_ready)
        got.push_back({sym.sym_is_dc, sym.sym_zrl, sym.sym_eob, sym.sym_run, sym.sym_value});
      if (sym.blk_done) break;
      tick();
      n++;
    end
    nvec++;
    if (sym.blk_done !== 1'b1) begin
      nerr++;
      $display("FAIL %s done_timeout: blk_done=%b required 1", name, sym.blk_done);
    end
    nvec++;
    if (got.size() != exp_q.size()) begin
      nerr++;
      $display("FAIL %s count: got %0d symbols required %0d", name, got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      nvec++;
      if (got[i] !== exp_q[i]) begin
        nerr++;
        $display("FAIL %s sym%0d: got %h required %h", name, i, got[i], exp_q[i]);
      end
    end
    tick();
    nvec++;
    if (sym.blk_done !== 1'b0 || blk.blk_ready !== 1'b1) begin
      nerr++;
      $display("FAIL %s done_pulse: done=%b ready=%b required 0 1", name, sym.blk_done, blk.blk_ready);
    end
  endtask

  task automatic test_reset();
    #12;
    nvec++;
    if ({blk.blk_ready, sym.sym_valid, sym.blk_done, sym.sym_is_dc, sym.sym_zrl, sym.sym_eob,
         sym.sym_run, sym.sym_value} !== {3'b100, 3'b000, 4'd0, 9'd0}) begin
      nerr++;
      $display("FAIL reset_outputs: ready=%b valid=%b done=%b run=%0d value=%0d required 1 0 0 0 0",
               blk.blk_ready, sym.sym_valid, sym.blk_done, sym.sym_run, sym.sym_value);
    end
    tick();
    rst_n = 1'b1;
    tick();
    nvec++;
    if (blk.blk_ready !== 1'b1 || sym.sym_valid !== 1'b0) begin
      nerr++;
      $display("FAIL reset_release: ready=%b valid=%b required 1 0", blk.blk_ready, sym.sym_valid);
    end
  endtask

  task automatic test_dc_only();
    exp_q = {s(1, 0, 0, 0, 5), s(0, 0, 1, 0, 0)};
    send(blkv(5, 0, 0, 0, 0), 1'b0);
    collect(1'b1, "dc5");
    exp_q = {s(1, 0, 0, 0, -2), s(0, 0, 1, 0, 0)};
    send(blkv(3, 0, 0, 0, 0), 1'b0);
    collect(1'b1, "dc3");
  endtask

  task automatic test_ac_zrl();
    exp_q = {s(1, 0, 0, 0, 0), s(0, 0, 0, 0, -1), s(0, 1, 0, 15, 0), s(0, 0, 0, 2, 7), s(0, 0, 1, 0, 0)};
    send(blkv(0, 1, -1, 20, 7), 1'b1);
    collect(1'b1, "ac_zrl");
  endtask

  task automatic test_last_coef();
    exp_q = {s(1, 0, 0, 0, 0), s(0, 1, 0, 15, 0), s(0, 1, 0, 15, 0), s(0, 1, 0, 15, 0), s(0, 0, 0, 14, 4)};
    send(blkv(0, 63, 4, 0, 0), 1'b0);
    collect(1'b1, "last_coef");
  endtask

  task automatic test_dc_extremes();
    exp_q = {s(1, 0, 0, 0, 127), s(0, 0, 1, 0, 0)};
    send(blkv(127, 0, 0, 0, 0), 1'b0);
    collect(1'b1, "dc127");
    exp_q = {s(1, 0, 0, 0, -255), s(0, 0, 1, 0, 0)};
    send(blkv(-128, 0, 0, 0, 0), 1'b0);
    collect(1'b1, "dcm128");
  endtask

  task automatic test_pred_clr();
    blk.dc_pred_clr = 1'b1;
    tick();
    blk.dc_pred_clr = 1'b0;
    exp_q = {s(1, 0, 0, 0, -7), s(0, 0, 1, 0, 0)};
    send(blkv(-7, 0, 0, 0, 0), 1'b0);
    collect(1'b1, "clr_idle");
    exp_q = {s(1, 0, 0, 0, 9), s(0, 0, 1, 0, 0)};
    send(blkv(9, 0, 0, 0, 0), 1'b1);
    collect(1'b1, "clr_capture");
  endtask

  task automatic test_stall();
    int n = 0;
    send(blkv(0, 2, 5, 0, 0), 1'b0);
    while (!(sym.sym_valid && !sym.sym_is_dc) && n < 50) begin
      tick();
      n++;
    end
    sym.sym_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      nvec++;
      if ({sym.sym_valid, sym.sym_zrl, sym.sym_eob, sym.sym_run, sym.sym_value} !== {3'b100, 4'd1, 9'd5}
          || dut.idx_q !== 6'd2) begin
        nerr++;
        $display("FAIL stall_hold%0d: valid=%b run=%0d value=%0d idx=%0d required 1 1 5 2",
                 c, sym.sym_valid, sym.sym_run, sym.sym_value, dut.idx_q);
      end
    end
    sym.sym_ready = 1'b1;
    tick();
    nvec++;
    if (sym.sym_valid !== 1'b0 || dut.idx_q !== 6'd3) begin
      nerr++;
      $display("FAIL stall_release: valid=%b idx=%0d required 0 3", sym.sym_valid, dut.idx_q);
    end
    exp_q = {s(0, 0, 1, 0, 0)};
    collect(1'b0, "stall_tail");
  endtask

  task automatic test_reset_mid();
    send(blkv(1, 40, 3, 0, 0), 1'b0);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    nvec++;
    if (sym.sym_valid !== 1'b0 || blk.blk_ready !== 1'b1) begin
      nerr++;
      $display("FAIL reset_mid: valid=%b ready=%b required 0 1", sym.sym_valid, blk.blk_ready);
    end
    tick();
    rst_n = 1'b1;
    tick();
    exp_q = {s(1, 0, 0, 0, 6), s(0, 0, 1, 0, 0)};
    send(blkv(6, 0, 0, 0, 0), 1'b0);
    collect(1'b1, "after_reset");
  endtask

  initial begin
    blk.blk_valid = 1'b0;
    blk.dc_pred_clr = 1'b0;
    blk.zigzag_pix_in = '0;
    sym.sym_ready = 1'b1;
    test_reset();
    test_dc_only();
    test_ac_zrl();
    test_last_coef();
    test_dc_extremes();
    test_pred_clr();
    test_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
